sys_timer_seq: RTL and testbench
================================

Name: sys_timer_seq

Overview:
Parametrised successor to the accelerator's E-clock timing block. It generates DRAM refresh request and urgency flags from the synchronised 68K E clock. It runs the power-on/reset startup sequencer that drives PDS reset, bus request and address-output enable. It also maintains N independent I/O quality-of-service (QoS) hold-off timers. Unlike the earlier single-channel block, it adds:
- configurable refresh period and urgency window
- saturating, per-phase-cleared long timer
- an explicit synchronous reset
- per-channel QoS enables
- status outputs

Parameters:
REF_PERIOD, 11, E-clock falling edges per refresh cycle (>=3)
REF_URG, 2, number of E ticks before end of period during which RefUrg is asserted (1..REF_PERIOD-2)
LT_W, 12, long-timer width in bits
LT_TERM, 3072, refresh cycles per startup phase (< 2^LT_W)
QOS_CH, 3, number of QoS channels (>=1)
QOS_W, 4, QoS timer width
QOS_LOAD, 15, QoS reload value in refresh cycles (< 2^QOS_W)

Ports:
CLK  in  1  FSB clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
E  in  1  68K E clock, asynchronous
nRESin  in  1  PDS reset line, asynchronous, active low
nIPL2  in  1  NMI button level, asynchronous, active low
BACT  in  1  bus cycle active
QoSCS  in  QOS_CH  per-channel chip-select hits
RefReq  out  1  refresh requested
RefUrg  out  1  refresh urgent
RefTick  out  1  one-CLK pulse per completed refresh period
nRESout  out  1  reset to Mac, active low
AoutOE  out  1  PDS address/control output enable
nBR_IOB  out  1  bus request to I/O board, active low
QoSEN  out  QOS_CH  per-channel QoS enable
QoSAny  out  1  OR of QoSEN
IS  out  2  startup state: 0 HOLD, 1 NMICHK, 2 GRANT, 3 RUN

Behaviour:
- Synchronisers: E, nRESin and nIPL2 each pass through 2 flops. EFall is a 1-CLK pulse when the synced E goes 1->0.
- Reset values (RST=1, next edge):
  - Timer=0, RefReq=0, RefUrg=0, RefTick=0, LTimer=0
  - IS=0, nRESout=0, AoutOE=0, nBR_IOB=0, LookReset=0
  - all QoS counters=0, QoSEN=0
  - RST overrides every other event.
- Refresh timer: counts 0..REF_PERIOD-1 on EFall only, then wraps to 0. On each EFall, using the pre-increment Timer value:
  - RefReq <= (Timer != REF_PERIOD-1)
  - RefUrg <= (Timer >= REF_PERIOD-1-REF_URG) && (Timer < REF_PERIOD-1)
  - RefTick <= (Timer == REF_PERIOD-1); otherwise RefTick=0 next cycle.
  - Default parameters: RefUrg is high after Timer values 8 and 9; RefReq goes low for one E period after 10.
- Long timer:
  - Increments on RefTick and saturates at LT_TERM (no wrap).
  - Clears to 0 on every IS transition.
  - PhaseDone = (LTimer == LT_TERM).
- Startup FSM:
  - HOLD:
    - Outputs: nRESout=0, AoutOE=0, nBR_IOB=0.
    - PhaseDone -> NMICHK.
  - NMICHK:
    - Outputs: nRESout=0, AoutOE=0.
    - nBR_IOB latches to 1 once synced nIPL2 is low while nBR_IOB=0; it stays latched for the rest of the phase.
    - PhaseDone && nIPL2 synced high -> GRANT. PhaseDone with NMI held: stay; LTimer stays saturated.
  - GRANT:
    - Outputs: nRESout=0, AoutOE = !nBR_IOB (registered).
    - PhaseDone -> RUN.
  - RUN:
    - Outputs: nRESout=1; AoutOE and nBR_IOB hold their values.
    - LookReset is cleared while nRESout=0 and set on the first EFall while nRESout=1.
    - LookReset && synced nRESin low -> HOLD. The block's own nRESout release cannot self-trigger re-entry.
- QoS channel i:
  - hit_i is registered: BACT && QoSCS[i], or synced nRESin low (loads all channels).
  - hit_i -> counter = QOS_LOAD. Otherwise RefTick && counter != 0 -> decrement. At 0 the counter holds 0.
  - Load wins over a simultaneous decrement.
  - QoSEN[i] <= (counter != 0), updated only in cycles where BACT=0; otherwise it holds.
  - QoSAny is registered with QoSEN.
- Mid-operation RST: the FSM returns to HOLD immediately, nRESout drops the next cycle, and all timers restart.

Test Plan:
- RST then E square wave (period 20 CLK, default params) -> RefReq rises on the first EFall. RefUrg is high exactly during the E periods following Timer 8 and 9. RefReq=0 for one E period per 11. RefTick pulses once per 11 EFalls.
- Startup with LT_TERM=4, nIPL2=1 -> IS steps 0->1->2->3 every 4 RefTicks. AoutOE=1 in GRANT; nRESout rises on entering RUN; nBR_IOB=0 throughout.
- Startup with nIPL2 low during NMICHK -> nBR_IOB=1 latched and AoutOE stays 0 in GRANT. With nIPL2 held low past PhaseDone, IS stays 1 until release, then moves to 2 on the next cycle.
- In RUN, pull nRESin low for 3 E periods -> IS=0, nRESout=0, all QoSEN=1 once BACT=0. Repeat with a RST pulse mid-GRANT -> all outputs return to reset values on the next edge.
- QOS_CH=3, BACT=1 with QoSCS=3'b010 -> channel 1 counter=15; after BACT drops, QoSEN=3'b010. After 15 RefTicks QoSEN returns to 0. A hit coincident with RefTick reloads to 15, with no decrement.
- Sweep parameters REF_PERIOD=5, REF_URG=1, QOS_W=2, QOS_LOAD=3 -> RefUrg high only after Timer=3. QoS counters expire after 3 ticks with no wrap below 0.

Source files
------------

// File: rtl/sys_timer_seq.sv
// sys_timer_seq: E-clock refresh timer, power-on startup sequencer and I/O QoS hold-off timers.
//
// Ports:
//   clk_i       FSB clock, all state on the rising edge
//   rst_i       synchronous active-high reset, overrides every other event
//   e_i         68K E clock (asynchronous, synchronised here)
//   nres_i      PDS reset line, active low (asynchronous)
//   nipl2_i     NMI button level, active low (asynchronous)
//   bact_i      bus cycle active
//   qos_cs_i    per-channel QoS chip-select hits
//   ref_req_o   refresh requested
//   ref_urg_o   refresh urgent
//   ref_tick_o  one-clock pulse per completed refresh period
//   nres_o      reset to Mac, active low
//   aout_oe_o   PDS address/control output enable
//   nbr_iob_o   bus request to I/O board, active low
//   qos_en_o    per-channel QoS enable
//   qos_any_o   OR of qos_en_o
//   is_o        startup state: 0 HOLD, 1 NMICHK, 2 GRANT, 3 RUN
module sys_timer_seq #(
  parameter int unsigned REF_PERIOD = 11,
  parameter int unsigned REF_URG    = 2,
  parameter int unsigned LT_W       = 12,
  parameter int unsigned LT_TERM    = 3072,
  parameter int unsigned QOS_CH     = 3,
  parameter int unsigned QOS_W      = 4,
  parameter int unsigned QOS_LOAD   = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_i,
  input  logic              nres_i,
  input  logic              nipl2_i,
  input  logic              bact_i,
  input  logic [QOS_CH-1:0] qos_cs_i,
  output logic              ref_req_o,
  output logic              ref_urg_o,
  output logic              ref_tick_o,
  output logic              nres_o,
  output logic              aout_oe_o,
  output logic              nbr_iob_o,
  output logic [QOS_CH-1:0] qos_en_o,
  output logic              qos_any_o,
  output logic [1:0]        is_o
);

  localparam int unsigned     TW      = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0]   TMax    = TW'(REF_PERIOD - 1);
  localparam logic [TW-1:0]   UrgLo   = TW'(REF_PERIOD - 1 - REF_URG);
  localparam logic [LT_W-1:0] LtTerm  = LT_W'(LT_TERM);
  localparam logic [QOS_W-1:0] QosLoad = QOS_W'(QOS_LOAD);

  typedef enum logic [1:0] {StHold = 2'd0, StNmiChk = 2'd1, StGrant = 2'd2, StRun = 2'd3} state_e;

  // Two-flop synchronisers. Active-low lines reset to their inactive level so that
  // leaving reset cannot fake a PDS reset or an NMI.
  logic [1:0] e_sync_q, nres_sync_q, nipl2_sync_q;
  logic       e_last_q;
  logic       efall, nres_s, nipl2_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_sync_q     <= 2'b00;
      e_last_q     <= 1'b0;
      nres_sync_q  <= 2'b11;
      nipl2_sync_q <= 2'b11;
    end else begin
      e_sync_q     <= {e_sync_q[0], e_i};
      e_last_q     <= e_sync_q[1];
      nres_sync_q  <= {nres_sync_q[0], nres_i};
      nipl2_sync_q <= {nipl2_sync_q[0], nipl2_i};
    end
  end

  assign efall   = e_last_q & ~e_sync_q[1];
  assign nres_s  = nres_sync_q[1];
  assign nipl2_s = nipl2_sync_q[1];

  // Refresh timer; flags are decoded from the pre-increment count.
  logic [TW-1:0] timer_q;
  logic          ref_req_q, ref_urg_q, ref_tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q    <= '0;
      ref_req_q  <= 1'b0;
      ref_urg_q  <= 1'b0;
      ref_tick_q <= 1'b0;
    end else if (efall) begin
      timer_q    <= (timer_q == TMax) ? '0 : timer_q + TW'(1);
      ref_req_q  <= (timer_q != TMax);
      ref_urg_q  <= (timer_q >= UrgLo) && (timer_q < TMax);
      ref_tick_q <= (timer_q == TMax);
    end else begin
      ref_tick_q <= 1'b0;
    end
  end

  // Startup sequencer with the long timer; every state change restarts the long timer.
  state_e          st_q;
  logic [LT_W-1:0] lt_q;
  logic            nres_q, aout_oe_q, nbr_iob_q, look_reset_q;
  logic            phase_done;

  assign phase_done = (lt_q == LtTerm);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q         <= StHold;
      lt_q         <= '0;
      nres_q       <= 1'b0;
      aout_oe_q    <= 1'b0;
      nbr_iob_q    <= 1'b0;
      look_reset_q <= 1'b0;
    end else begin
      // Arm reset detection only after an E edge with nRESout released, so our own
      // release (seen back through the PDS reset line) cannot re-enter HOLD.
      if (!nres_q) begin
        look_reset_q <= 1'b0;
      end else if (efall) begin
        look_reset_q <= 1'b1;
      end
      if (ref_tick_q && !phase_done) begin
        lt_q <= lt_q + LT_W'(1);
      end
      unique case (st_q)
        StHold: begin
          nres_q    <= 1'b0;
          aout_oe_q <= 1'b0;
          nbr_iob_q <= 1'b0;
          if (phase_done) begin
            st_q <= StNmiChk;
            lt_q <= '0;
          end
        end
        StNmiChk: begin
          if (!nipl2_s) begin
            nbr_iob_q <= 1'b1;
          end
          // NMI held past phase end keeps us here with the long timer saturated.
          if (phase_done && nipl2_s) begin
            st_q      <= StGrant;
            lt_q      <= '0;
            aout_oe_q <= ~nbr_iob_q;
          end
        end
        StGrant: begin
          aout_oe_q <= ~nbr_iob_q;
          if (phase_done) begin
            st_q   <= StRun;
            lt_q   <= '0;
            nres_q <= 1'b1;
          end
        end
        StRun: begin
          if (look_reset_q && !nres_s) begin
            st_q      <= StHold;
            lt_q      <= '0;
            nres_q    <= 1'b0;
            aout_oe_q <= 1'b0;
            nbr_iob_q <= 1'b0;
          end
        end
        default: st_q <= StHold;
      endcase
    end
  end

  // QoS hold-off channels. A registered hit reloads; a PDS reset loads every channel.
  logic [QOS_CH-1:0] cnt_nz;
  logic [QOS_CH-1:0] qos_en_d, qos_en_q;
  logic              qos_any_q;

  for (genvar i = 0; i < QOS_CH; i++) begin : g_qos
    logic             hit_q;
    logic [QOS_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hit_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        hit_q <= (bact_i && qos_cs_i[i]) || !nres_s;
        if (hit_q) begin
          cnt_q <= QosLoad;
        end else if (ref_tick_q && (cnt_q != '0)) begin
          cnt_q <= cnt_q - QOS_W'(1);
        end
      end
    end

    assign cnt_nz[i] = (cnt_q != '0);
  end

  // Enables only change between bus cycles.
  always_comb begin
    qos_en_d = qos_en_q;
    if (!bact_i) begin
      qos_en_d = cnt_nz;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qos_en_q  <= '0;
      qos_any_q <= 1'b0;
    end else begin
      qos_en_q  <= qos_en_d;
      qos_any_q <= |qos_en_d;
    end
  end

  assign ref_req_o  = ref_req_q;
  assign ref_urg_o  = ref_urg_q;
  assign ref_tick_o = ref_tick_q;
  assign nres_o     = nres_q;
  assign aout_oe_o  = aout_oe_q;
  assign nbr_iob_o  = nbr_iob_q;
  assign qos_en_o   = qos_en_q;
  assign qos_any_o  = qos_any_q;
  assign is_o       = st_q;

endmodule

// File: tb/tb_sys_timer_seq.sv
// tb_sys_timer_seq: directed bench for sys_timer_seq. Instance a uses default refresh/QoS
// settings with a short startup phase; instance b uses the small-parameter sweep.
module tb_sys_timer_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e;
  logic       nres_in = 1'b1;
  logic       nipl2 = 1'b1;
  logic       bact = 1'b0;
  logic [2:0] cs = 3'b000;
  logic       e_en = 1'b0;

  logic       a_req, a_urg, a_tick, a_nres, a_aout, a_nbr, a_qany;
  logic [2:0] a_qen;
  logic [1:0] a_is;
  logic       b_req, b_urg, b_tick, b_nres, b_aout, b_nbr, b_qany;
  logic [2:0] b_qen;
  logic [1:0] b_is;
  logic [11:0] out_a, out_b;

  int errors = 0;
  int checks = 0;
  int fall_cnt = 0;
  int e_div = 0;
  int tick_a = 0;
  int tick_b = 0;

  always #5 clk = ~clk;

  sys_timer_seq #(.LT_TERM(4)) u_a (
    .clk_i(clk), .rst_i(rst), .e_i(e), .nres_i(nres_in), .nipl2_i(nipl2), .bact_i(bact),
    .qos_cs_i(cs), .ref_req_o(a_req), .ref_urg_o(a_urg), .ref_tick_o(a_tick),
    .nres_o(a_nres), .aout_oe_o(a_aout), .nbr_iob_o(a_nbr), .qos_en_o(a_qen),
    .qos_any_o(a_qany), .is_o(a_is)
  );

  sys_timer_seq #(
    .REF_PERIOD(5), .REF_URG(1), .LT_TERM(4), .QOS_W(2), .QOS_LOAD(3)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .e_i(e), .nres_i(nres_in), .nipl2_i(nipl2), .bact_i(bact),
    .qos_cs_i(cs), .ref_req_o(b_req), .ref_urg_o(b_urg), .ref_tick_o(b_tick),
    .nres_o(b_nres), .aout_oe_o(b_aout), .nbr_iob_o(b_nbr), .qos_en_o(b_qen),
    .qos_any_o(b_qany), .is_o(b_is)
  );

  assign out_a = {a_req, a_urg, a_tick, a_nres, a_aout, a_nbr, a_qen, a_qany, a_is};
  assign out_b = {b_req, b_urg, b_tick, b_nres, b_aout, b_nbr, b_qen, b_qany, b_is};

  // E square wave, 20 clocks per period, held high while disabled.
  initial begin
    e = 1'b1;
    forever begin
      @(negedge clk);
      if (!e_en) begin
        e = 1'b1;
        e_div = 0;
        fall_cnt = 0;
      end else begin
        e_div = e_div + 1;
        if (e_div == 10) begin
          e_div = 0;
          e = ~e;
          if (!e) fall_cnt = fall_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (a_tick) tick_a <= tick_a + 1;
    if (b_tick) tick_b <= tick_b + 1;
  end

  task automatic do_reset();
    e_en = 1'b0; rst = 1'b1; nres_in = 1'b1; nipl2 = 1'b1; bact = 1'b0; cs = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Return 8 clocks after the next E fall, well after the DUT has registered it.
  task automatic next_fall();
    int start = fall_cnt;
    int n = 0;
    while (fall_cnt == start && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (fall_cnt == start) begin
      checks++; errors++;
      $display("FAIL efall_wait: no E fall within 100 cycles");
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic run_falls(input int n);
    repeat (n) next_fall();
  endtask

  task automatic wait_ticks_a(input int n);
    int start = tick_a;
    int c = 0;
    while (tick_a < start + n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (tick_a < start + n) begin
      checks++; errors++;
      $display("FAIL tick_wait: saw %0d RefTicks, required %0d", tick_a - start, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_a !== 12'h000) begin
      errors++; $display("FAIL reset_a: got %h, want 000", out_a);
    end
    checks++;
    if (out_b !== 12'h000) begin
      errors++; $display("FAIL reset_b: got %h, want 000", out_b);
    end
  endtask

  task automatic test_refresh();
    int base;
    int pre;
    do_reset();
    base = tick_a;
    e_en = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      next_fall();
      pre = (k - 1) % 11;
      checks++;
      if (a_req !== (pre != 10)) begin
        errors++; $display("FAIL refreq k=%0d: got %b, want %b", k, a_req, pre != 10);
      end
      checks++;
      if (a_urg !== (pre == 8 || pre == 9)) begin
        errors++; $display("FAIL refurg k=%0d: got %b, want %b", k, a_urg, pre == 8 || pre == 9);
      end
      checks++;
      if (a_tick !== 1'b0) begin
        errors++; $display("FAIL reftick_width k=%0d: got %b, want 0", k, a_tick);
      end
    end
    checks++;
    if (tick_a - base !== 2) begin
      errors++; $display("FAIL reftick_count: got %0d, want 2", tick_a - base);
    end
  endtask

  task automatic test_startup();
    logic [1:0] exp_is;
    do_reset();
    e_en = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      next_fall();
      exp_is = (k >= 132) ? 2'd3 : (k >= 88) ? 2'd2 : (k >= 44) ? 2'd1 : 2'd0;
      checks++;
      if (a_is !== exp_is) begin
        errors++; $display("FAIL startup_is k=%0d: got %0d, want %0d", k, a_is, exp_is);
      end
      checks++;
      if ({a_nres, a_aout, a_nbr} !== {exp_is == 2'd3, exp_is >= 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL startup_out k=%0d: got nres/aout/nbr=%b%b%b, want %b%b0", k, a_nres,
                 a_aout, a_nbr, exp_is == 2'd3, exp_is >= 2'd2);
      end
    end
  endtask

  task automatic test_nmi();
    do_reset();
    e_en = 1'b1;
    run_falls(50);
    checks++;
    if (a_is !== 2'd1) begin
      errors++; $display("FAIL nmi_state: got %0d, want 1", a_is);
    end
    nipl2 = 1'b0;
    run_falls(1);
    checks++;
    if (a_nbr !== 1'b1) begin
      errors++; $display("FAIL nmi_latch: got nbr=%b, want 1", a_nbr);
    end
    run_falls(44);
    checks++;
    if ({a_is, a_nbr} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL nmi_hold: got is=%0d nbr=%b, want is=1 nbr=1", a_is, a_nbr);
    end
    nipl2 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_is !== 2'd1) begin
      errors++; $display("FAIL nmi_release_early: got %0d, want 1", a_is);
    end
    @(negedge clk);
    checks++;
    if ({a_is, a_aout, a_nbr} !== {2'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL nmi_grant: got is=%0d aout=%b nbr=%b, want 2 0 1", a_is, a_aout, a_nbr);
    end
    run_falls(38);
    checks++;
    if ({a_is, a_nres, a_aout, a_nbr} !== {2'd3, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL nmi_run: got is=%0d nres=%b aout=%b nbr=%b, want 3 1 0 1", a_is, a_nres,
               a_aout, a_nbr);
    end
  endtask

  task automatic test_nres_reentry();
    do_reset();
    e_en = 1'b1;
    run_falls(135);
    checks++;
    if ({a_is, a_nres} !== {2'd3, 1'b1}) begin
      errors++; $display("FAIL reentry_run: got is=%0d nres=%b, want 3 1", a_is, a_nres);
    end
    nres_in = 1'b0;
    run_falls(1);
    checks++;
    if ({a_is, a_nres, a_aout, a_nbr} !== {2'd0, 3'b000}) begin
      errors++;
      $display("FAIL reentry_hold: got is=%0d nres=%b aout=%b nbr=%b, want 0 0 0 0", a_is,
               a_nres, a_aout, a_nbr);
    end
    checks++;
    if ({a_qen, a_qany} !== 4'b1111) begin
      errors++; $display("FAIL reentry_qos: got en=%b any=%b, want 111 1", a_qen, a_qany);
    end
    run_falls(2);
    nres_in = 1'b1;
    run_falls(2);
    checks++;
    if ({a_is, a_nres} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL reentry_stay: got is=%0d nres=%b, want 0 0", a_is, a_nres);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    e_en = 1'b1;
    run_falls(100);
    checks++;
    if ({a_is, a_aout, a_req} !== {2'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL grant_pre: got is=%0d aout=%b req=%b, want 2 1 1", a_is, a_aout,
                         a_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_a !== 12'h000) begin
      errors++; $display("FAIL rst_mid: got %h, want 000", out_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_qos();
    int last;
    int n;
    do_reset();
    e_en = 1'b1;
    bact = 1'b1; cs = 3'b010;
    @(negedge clk);
    bact = 1'b0; cs = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_qen, a_qany} !== 4'b0101) begin
      errors++; $display("FAIL qos_load: got en=%b any=%b, want 010 1", a_qen, a_qany);
    end
    wait_ticks_a(14);
    checks++;
    if (a_qen !== 3'b010) begin
      errors++; $display("FAIL qos_14: got %b, want 010", a_qen);
    end
    wait_ticks_a(1);
    checks++;
    if ({a_qen, a_qany} !== 4'b0000) begin
      errors++; $display("FAIL qos_expire: got en=%b any=%b, want 000 0", a_qen, a_qany);
    end
    // Hit registered in exactly the cycle RefTick is high.
    last = fall_cnt;
    n = 0;
    while (!(fall_cnt != last && fall_cnt % 11 == 0) && n < 600) begin
      last = fall_cnt;
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    bact = 1'b1; cs = 3'b001;
    @(negedge clk);
    checks++;
    if (a_tick !== 1'b1) begin
      errors++; $display("FAIL qos_coincide_tick: got %b, want 1", a_tick);
    end
    bact = 1'b0; cs = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (a_qen !== 3'b001) begin
      errors++; $display("FAIL qos_coincide_load: got %b, want 001", a_qen);
    end
    wait_ticks_a(14);
    checks++;
    if (a_qen !== 3'b001) begin
      errors++; $display("FAIL qos_coincide_14: got %b, want 001", a_qen);
    end
    wait_ticks_a(1);
    checks++;
    if (a_qen !== 3'b000) begin
      errors++; $display("FAIL qos_coincide_expire: got %b, want 000", a_qen);
    end
  endtask

  task automatic test_sweep();
    int pre;
    int base;
    do_reset();
    base = tick_b;
    e_en = 1'b1;
    bact = 1'b1; cs = 3'b100;
    @(negedge clk);
    bact = 1'b0; cs = 3'b000;
    for (int k = 1; k <= 22; k++) begin
      next_fall();
      pre = (k - 1) % 5;
      checks++;
      if ({b_req, b_urg} !== {pre != 4, pre == 3}) begin
        errors++; $display("FAIL sweep_ref k=%0d: got req=%b urg=%b, want %b %b", k, b_req,
                           b_urg, pre != 4, pre == 3);
      end
      checks++;
      if (b_qen !== ((k < 15) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL sweep_qos k=%0d: got %b, want %b", k, b_qen,
                           (k < 15) ? 3'b100 : 3'b000);
      end
    end
    checks++;
    if (tick_b - base !== 4) begin
      errors++; $display("FAIL sweep_ticks: got %0d, want 4", tick_b - base);
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_startup();
    test_nmi();
    test_nres_reentry();
    test_rst_mid();
    test_qos();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
